// File: rtl/vec_mag_isqrt.sv
// vec_mag_isqrt: iterative, handshaked vector magnitude.
// Computes floor(sqrt(dx^2 + dy^2)) with a restoring digit-by-digit square
// root (one root bit per cycle, MSB first) and reports the remainder
// dx^2 + dy^2 - root^2.
// Optional build macro VEC_MAG_ROUND_EN: when defined, magnitude is rounded to
// nearest (root + 1 when rem > root). The remainder stays relative to the
// floor root.
module vec_mag_isqrt #(
    parameter int IN_W      = 8,
    parameter int SIGNED_IN = 0,
    localparam int OUT_W    = IN_W + 1,
    localparam int REM_W    = OUT_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  dx,
    input  logic [IN_W-1:0]  dy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] magnitude,
    output logic [REM_W-1:0] remainder
);

    localparam int RAD_W = 2 * IN_W + 1;   // exact width of dx^2 + dy^2
    localparam int EXT_W = 2 * OUT_W;      // radicand padded to whole bit pairs
    localparam int ACC_W = REM_W + 2;      // shifted partial remainder
    localparam int CNT_W = $clog2(OUT_W);

    typedef enum logic [1:0] {IDLE, SQUARE, ITER, DONE} state_t;

    state_t             state_q, state_d;
    logic [IN_W-1:0]    a_q, a_d;
    logic [IN_W-1:0]    b_q, b_d;
    logic [EXT_W-1:0]   rad_q, rad_d;
    logic [OUT_W-1:0]   root_q, root_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   mag_q, mag_d;
    logic [REM_W-1:0]   remo_q, remo_d;

    logic [IN_W-1:0]    dx_abs, dy_abs;
    logic [RAD_W-1:0]   sq_sum;
    logic [ACC_W-1:0]   rem_sh, trial;
    logic [OUT_W-1:0]   root_nx;
    logic [REM_W-1:0]   rem_nx;

    // Magnitude of the operands; the most negative value maps to 2^(IN_W-1),
    // which still fits in IN_W unsigned bits.
    generate
        if (SIGNED_IN != 0) begin : g_signed
            assign dx_abs = dx[IN_W-1] ? -dx : dx;
            assign dy_abs = dy[IN_W-1] ? -dy : dy;
        end else begin : g_unsigned
            assign dx_abs = dx;
            assign dy_abs = dy;
        end
    endgenerate

    // Full-width radicand and one restoring square-root step.
    always_comb begin
        sq_sum  = RAD_W'(a_q) * RAD_W'(a_q) + RAD_W'(b_q) * RAD_W'(b_q);
        rem_sh  = {rem_q, rad_q[{cnt_q, 1'b0} +: 2]};
        trial   = {1'b0, root_q, 2'b01};
        if (rem_sh >= trial) begin
            rem_nx  = REM_W'(rem_sh - trial);
            root_nx = {root_q[OUT_W-2:0], 1'b1};
        end else begin
            rem_nx  = REM_W'(rem_sh);
            root_nx = {root_q[OUT_W-2:0], 1'b0};
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        rad_d   = rad_q;
        root_d  = root_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        mag_d   = mag_q;
        remo_d  = remo_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = dx_abs;
                    b_d     = dy_abs;
                    state_d = SQUARE;
                end
            end
            SQUARE: begin
                rad_d   = EXT_W'(sq_sum);
                root_d  = '0;
                rem_d   = '0;
                cnt_d   = CNT_W'(OUT_W - 1);
                state_d = ITER;
            end
            ITER: begin
                root_d = root_nx;
                rem_d  = rem_nx;
                if (cnt_q == '0) begin
                    // Results are latched only on entry to DONE.
`ifdef VEC_MAG_ROUND_EN
                    mag_d = (rem_nx > {1'b0, root_nx}) ? root_nx + 1'b1 : root_nx;
`else
                    mag_d = root_nx;
`endif
                    remo_d  = rem_nx;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            rad_q   <= '0;
            root_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            mag_q   <= '0;
            remo_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rad_q   <= rad_d;
            root_q  <= root_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            mag_q   <= mag_d;
            remo_q  <= remo_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign magnitude = mag_q;
    assign remainder = remo_q;

endmodule

// File: tb/tb_vec_mag_isqrt.sv
// Testbench for vec_mag_isqrt: an unsigned and a signed instance share the
// same stimulus; results are checked against an arithmetic isqrt model.
module tb_vec_mag_isqrt;

    localparam int LAT = 10;   // edges from accept edge to out_valid (IN_W=8)

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] dx, dy;
    logic       in_ready_u, out_valid_u, in_ready_s, out_valid_s;
    logic [8:0] mag_u, mag_s;
    logic [9:0] rem_u, rem_s;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vec_mag_isqrt #(.IN_W(8), .SIGNED_IN(0)) dut_u (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
        .dx(dx), .dy(dy), .out_valid(out_valid_u), .out_ready(out_ready),
        .magnitude(mag_u), .remainder(rem_u)
    );

    vec_mag_isqrt #(.IN_W(8), .SIGNED_IN(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .dx(dx), .dy(dy), .out_valid(out_valid_s), .out_ready(out_ready),
        .magnitude(mag_s), .remainder(rem_s)
    );

    typedef struct {
        logic [7:0] dx;
        logic [7:0] dy;
        int         mag;
        int         rem;
    } vec_t;

    vec_t tbl[6];

    function automatic longint isqrt(input longint n);
        longint r = 0;
        while ((r + 1) * (r + 1) <= n) r++;
        return r;
    endfunction

    function automatic longint model_mag(input longint n);
        longint r = isqrt(n);
`ifdef VEC_MAG_ROUND_EN
        if (n - r * r > r) r++;
`endif
        return r;
    endfunction

    function automatic longint sabs(input logic [7:0] v);
        return v[7] ? (256 - longint'(v)) : longint'(v);
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Issue one operation (caller is #1 after an edge with both blocks idle),
    // wait for the result and compare both instances against the model.
    task automatic run_op(input logic [7:0] x, input logic [7:0] y, input string tag);
        longint nu, ns;
        int     lat;
        bit     busy_ok;
        nu = longint'(x) * x + longint'(y) * y;
        ns = sabs(x) * sabs(x) + sabs(y) * sabs(y);
        dx = x; dy = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dx = 8'($urandom);
        dy = 8'($urandom);
        lat = 0;
        busy_ok = 1'b1;
        while (!out_valid_u && lat < 40) begin
            if (in_ready_u || in_ready_s) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, lat, LAT);
        check({tag, " in_ready low while busy"}, busy_ok, 1);
        check({tag, " signed out_valid"}, out_valid_s, 1);
        check({tag, " magnitude"}, mag_u, model_mag(nu));
        check({tag, " remainder"}, rem_u, nu - isqrt(nu) * isqrt(nu));
        check({tag, " signed magnitude"}, mag_s, model_mag(ns));
        check({tag, " signed remainder"}, rem_s, ns - isqrt(ns) * isqrt(ns));
        $display("op %s dx=%0d dy=%0d -> mag=%0d rem=%0d | signed mag=%0d rem=%0d lat=%0d",
                 tag, x, y, mag_u, rem_u, mag_s, rem_s, lat);
        if (out_ready) begin
            @(posedge clk); #1;
            check({tag, " out_valid drops"}, out_valid_u, 0);
            check({tag, " in_ready returns"}, in_ready_u, 1);
        end
    endtask

    initial begin
        bit stable;
        tbl[0] = '{dx: 8'd3,   dy: 8'd4,   mag: 5,   rem: 0};
`ifdef VEC_MAG_ROUND_EN
        tbl[1] = '{dx: 8'd255, dy: 8'd255, mag: 361, rem: 450};
`else
        tbl[1] = '{dx: 8'd255, dy: 8'd255, mag: 360, rem: 450};
`endif
        tbl[2] = '{dx: 8'd0,   dy: 8'd0,   mag: 0,   rem: 0};
        tbl[3] = '{dx: 8'd1,   dy: 8'd2,   mag: 2,   rem: 1};
        tbl[4] = '{dx: 8'd6,   dy: 8'd8,   mag: 10,  rem: 0};
        tbl[5] = '{dx: 8'd255, dy: 8'd0,   mag: 255, rem: 0};

        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; dx = 8'd9; dy = 8'd9;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", in_ready_u, 1);
        check("reset out_valid", out_valid_u, 0);
        check("reset magnitude", mag_u, 0);
        check("reset remainder", rem_u, 0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors.
        for (int i = 0; i < 6; i++) begin
            run_op(tbl[i].dx, tbl[i].dy, $sformatf("vec%0d", i));
            check($sformatf("vec%0d table magnitude", i), mag_u, tbl[i].mag);
            check($sformatf("vec%0d table remainder", i), rem_u, tbl[i].rem);
        end

        // Signed extreme: |-128|^2 + |-1|^2 = 16385.
        run_op(8'h80, 8'hFF, "signed_min");
        check("signed_min magnitude 128", mag_s, 128);
        check("signed_min remainder 1", rem_s, 1);

        // Randomised operations.
        for (int i = 0; i < 30; i++) begin
            run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   $sformatf("rnd%0d", i));
        end

        // Backpressure: hold the result for 20 cycles.
        out_ready = 1'b0;
        run_op(8'd3, 8'd4, "bp");
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (!out_valid_u || mag_u != 9'd5 || rem_u != 10'd0 || in_ready_u) stable = 1'b0;
        end
        check("bp result held 20 cycles", stable, 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp out_valid after release", out_valid_u, 0);
        check("bp in_ready after release", in_ready_u, 1);
        check("bp magnitude kept outside DONE", mag_u, 5);
        out_ready = 1'b1;

        // Reset during the 4th iteration cycle.
        dx = 8'd100; dy = 8'd100; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid-op in_ready low", in_ready_u, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset magnitude", mag_u, 0);
        check("async reset remainder", rem_u, 0);
        check("async reset out_valid", out_valid_u, 0);
        check("async reset in_ready", in_ready_u, 1);
        dx = 8'd6; dy = 8'd8; in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("in_valid ignored in reset", in_ready_u, 1);
        check("no result during reset", out_valid_u, 0);
        rst_n = 1'b1;
        run_op(8'd6, 8'd8, "after_reset");
        check("after_reset magnitude 10", mag_u, 10);
        check("after_reset remainder 0", rem_u, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
